// File: rtl/nanotrade_pkg.sv
// Shared types and helpers for the nanotrade order ingress path.
package nanotrade_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frame_state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // XOR of the n least significant bytes of w
    function automatic logic [7:0] xor_reduce_bytes(input logic [63:0] w,
                                                    input int n);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (i < n) r = r ^ w[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Order FIFO with a registered head word; level drives full/empty.
module order_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    after_pop;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign head  = head_q;

    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        rd_ptr_d  = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d  = wr_ptr_q + AW'(push_ok);
        level_d   = level_q + LW'(push_ok) - LW'(pop_ok);
        after_pop = level_q - LW'(pop_ok);
        // Head register tracks the entry that will sit at the read pointer
        head_d = head_q;
        if (after_pop != '0) head_d = mem_q[rd_ptr_d];
        else if (push_ok)    head_d = push_data;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/order_frame_rx.sv
// Byte-serial order framer: sync, payload, XOR checksum, with timeout,
// saturating statistics and an order FIFO toward the matcher.
module order_frame_rx
    import nanotrade_pkg::*;
#(
    parameter int         ORDER_BYTES = 3,
    parameter int         DEPTH       = 4,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_byte,
    input  logic                       in_strobe,
    output logic [8*ORDER_BYTES-1:0]   ord_data,
    output logic                       ord_valid,
    input  logic                       ord_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 cnt_ok,
    output logic [7:0]                 cnt_bad,
    output logic [7:0]                 cnt_drop,
    output logic                       busy
);
    localparam int W = 8 * ORDER_BYTES;

    frame_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   acc_q, acc_d;
    logic [W-1:0] asm_q, asm_d;
    logic [15:0]  timer_q, timer_d;
    logic [7:0]   ok_q, ok_d, bad_q, bad_d, drop_q, drop_d;
    logic         push, pop, fifo_full, fifo_empty, expire;

    assign pop       = ord_valid && ord_ready;
    assign ord_valid = !fifo_empty;
    assign expire    = (timer_q == 16'(TIMEOUT - 1));
    assign busy      = (state_q != IDLE);
    assign cnt_ok    = ok_q;
    assign cnt_bad   = bad_q;
    assign cnt_drop  = drop_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        asm_d   = asm_q;
        timer_d = timer_q;
        ok_d    = ok_q;
        bad_d   = bad_q;
        drop_d  = drop_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_strobe && in_byte == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    acc_d   = '0;
                    timer_d = '0;
                end
            end
            PAYLOAD: begin
                if (in_strobe) begin
                    asm_d   = (asm_q << 8) | W'(in_byte);
                    acc_d   = acc_q ^ in_byte;
                    timer_d = '0;
                    if (idx_q == 4'(ORDER_BYTES - 1)) state_d = CHECK;
                    else idx_d = idx_q + 4'd1;
                end else if (expire) begin
                    state_d = IDLE;
                    bad_d   = sat_inc8(bad_q);
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            CHECK: begin
                if (in_strobe) begin
                    state_d = IDLE;
                    timer_d = '0;
                    if (in_byte != acc_q)         bad_d  = sat_inc8(bad_q);
                    else if (!fifo_full || pop) begin
                        push = 1'b1;
                        ok_d = sat_inc8(ok_q);
                    end else                      drop_d = sat_inc8(drop_q);
                end else if (expire) begin
                    state_d = IDLE;
                    bad_d   = sat_inc8(bad_q);
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            asm_q   <= '0;
            timer_q <= '0;
            ok_q    <= '0;
            bad_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            asm_q   <= asm_d;
            timer_q <= timer_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            drop_q  <= drop_d;
        end
    end

    order_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (asm_q),
        .pop       (pop),
        .head      (ord_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

endmodule

// File: doc/order_frame_rx.md
Name: order_frame_rx

Overview:
- Byte-serial order ingress front end for the nanotrade core.
- Accepts a byte stream from the 8-bit dedicated input pins plus a strobe, and frames it as sync, payload and XOR checksum.
- Validates each frame and buffers complete orders in a parametrised FIFO.
- Presents orders to the matching logic over a valid/ready handshake, and keeps saturating good, bad and dropped frame counters.

Parameters:
- ORDER_BYTES, 3, payload bytes per order; legal range 1..8; order word width = 8*ORDER_BYTES.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, maximum idle cycles between bytes of one frame before abort; legal range 1..65535.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous active-high reset.
- in_byte, input, 8, incoming byte.
- in_strobe, input, 1, in_byte valid this cycle (one byte per strobe).
- ord_data, output, 8*ORDER_BYTES, head order word; first payload byte in the MSBs.
- ord_valid, output, 1, FIFO not empty.
- ord_ready, input, 1, consumer accepts the head when ord_valid && ord_ready.
- fifo_level, output, $clog2(DEPTH)+1, current occupancy.
- cnt_ok, output, 8, frames accepted; saturates at 255.
- cnt_bad, output, 8, checksum failures plus timeouts; saturates at 255.
- cnt_drop, output, 8, valid frames lost to a full FIFO; saturates at 255.
- busy, output, 1, FSM not in IDLE.

Behaviour:
- Reset is asynchronous and active-high. While rst = 1:
  - FSM goes to IDLE; FIFO empties (pointers 0).
  - All counters clear; ord_valid = 0; ord_data = 0; fifo_level = 0; busy = 0.
- FSM states: IDLE, PAYLOAD, CHECK.
  - IDLE: a strobe with in_byte == SYNC_BYTE moves to PAYLOAD, clears the byte index, seeds the checksum accumulator to 0 and clears the timer. Any other byte is ignored; no counter changes.
  - PAYLOAD: each strobe shifts the byte into the assembly register and XORs it into the accumulator. The byte index increments; after byte ORDER_BYTES-1 the FSM moves to CHECK. A SYNC_BYTE value here is treated as data.
  - CHECK: on the next strobe, compare in_byte with the accumulator.
    - Match and FIFO can accept: push, cnt_ok++.
    - Match and FIFO full: discard, cnt_drop++.
    - Mismatch: discard, cnt_bad++.
    - Every case returns to IDLE.
- Timeout:
  - In PAYLOAD and CHECK the timer counts cycles without a strobe and resets on each strobe.
  - When the timer reaches TIMEOUT, the FSM returns to IDLE, cnt_bad++, and the partial frame is discarded.
  - A strobe arriving in the same cycle as expiry wins: it is processed and the timer resets.
- FIFO push and pop:
  - The push takes effect at the clock edge of the checksum strobe. ord_valid and ord_data reflect a push made into an empty FIFO one cycle later.
  - Pop occurs on ord_valid && ord_ready.
  - "FIFO can accept" means level < DEPTH, or level == DEPTH with a pop in the same cycle. The simultaneous push and pop at full succeeds and the level is unchanged.
  - A push and pop on a non-full FIFO leaves the level unchanged.
  - ord_data is registered from storage at the read pointer, with no fall-through beyond the one-cycle push latency.
  - ord_data holds its last value when the FIFO is empty.
- Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from fifo_level.
- The consumer must not change ord_ready's meaning mid-transfer. ord_data is stable while ord_valid && !ord_ready.
- Counters saturate at 8'hFF and never wrap. Increments are single-cycle.
- Back-to-back frames are legal: a SYNC strobe the cycle after a CHECK strobe starts a new frame.

Decomposition:
- Package nanotrade_pkg holds:
  - the state enum (IDLE, PAYLOAD, CHECK);
  - the default SYNC_BYTE constant;
  - a function xor_reduce_bytes used by the bench model;
  - a sat_inc8 function.
- One sub-module, order_fifo (parameters WIDTH, DEPTH), containing storage, pointers and level. It exposes push, pop, full, empty and level.
- Framing FSM, timer and counters live in order_frame_rx.

Test Plan:
1. Good frame: defaults, strobes A5,12,34,56,checksum 70 with ord_ready = 0.
   - Required: ord_valid = 1 one cycle after the 70 strobe.
   - Required: ord_data = 24'h123456, cnt_ok = 1, fifo_level = 1.
2. Bad checksum: A5,12,34,56,71.
   - Required: cnt_bad = 1, no push, busy = 0 after the last strobe.
3. Overflow: five good frames with ord_ready = 0.
   - Required: fifo_level = 4, cnt_ok = 4, cnt_drop = 1.
   - Required: draining yields the first four orders in order.
4. Full with simultaneous pop: FIFO holding 4, ord_ready = 1 in the checksum-strobe cycle of a new frame.
   - Required: push succeeds, level stays 4, cnt_drop unchanged.
5. Timeout: A5,12 then 255 idle cycles.
   - Required: return to IDLE, cnt_bad = 1.
   - Required: the subsequent full frame is accepted normally. A strobe at exactly cycle 255 is processed without abort.
6. Reset mid-frame and saturation:
   - rst pulse after A5,12 clears all state, and a following frame is accepted.
   - 300 bad frames leave cnt_bad = 255.
